display_buffer: RTL

Parametrised character store between the UART receive path and the HPDL1414 display scanner; successor to the fixed 15-character display memory. The write side takes characters and editing commands over a valid/ready handshake and tracks its own cursor. When the last position is full, it scrolls the line left over multiple cycles. The read side serves the scanner with one-cycle latency and overlays a blinking caret at the cursor position.

---
 rtl/hpdl_pkg.sv | 19 +
 rtl/display_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hpdl_pkg.sv
// Shared definitions for the HPDL1414 display path: write commands, buffer
// FSM states and default character codes.
package hpdl_pkg;

    localparam logic [1:0] CMD_CHAR      = 2'd0;
    localparam logic [1:0] CMD_BACKSPACE = 2'd1;
    localparam logic [1:0] CMD_CLEAR     = 2'd2;
    localparam logic [1:0] CMD_HOME      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCROLL,
        ST_CLEAR
    } state_e;

    localparam logic [7:0] CARET_CHR_DEF = 8'h5F;
    localparam logic [7:0] BLANK_CHR_DEF = 8'h20;

endpackage

// File: rtl/display_buffer.sv
// Character store between the UART receive path and the display scanner.
// Handshaked write side with cursor/scroll/clear; one-cycle read with caret overlay.
module display_buffer
    import hpdl_pkg::*;
#(
    parameter int unsigned           DISPLAY_LENGTH = 16,
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] CARET_CHR      = DATA_WIDTH'(CARET_CHR_DEF),
    parameter logic [DATA_WIDTH-1:0] BLANK_CHR      = DATA_WIDTH'(BLANK_CHR_DEF)
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_wr_valid,
    output logic                              o_wr_ready,
    input  logic [1:0]                        i_wr_cmd,
    input  logic [DATA_WIDTH-1:0]             i_wr_data,
    input  logic                              i_rd_en,
    input  logic [$clog2(DISPLAY_LENGTH)-1:0] i_rd_addr,
    input  logic                              i_caret_strobe,
    output logic [DATA_WIDTH-1:0]             o_rd_data,
    output logic [$clog2(DISPLAY_LENGTH)-1:0] o_cursor,
    output logic                              o_full
);

    localparam int unsigned    AW        = $clog2(DISPLAY_LENGTH);
    localparam logic [AW-1:0]  LastIdx   = AW'(DISPLAY_LENGTH - 1);
    localparam logic [AW-1:0]  PenultIdx = AW'(DISPLAY_LENGTH - 2);

    logic [DATA_WIDTH-1:0] mem_q [DISPLAY_LENGTH];
    logic [DATA_WIDTH-1:0] cell_wd [DISPLAY_LENGTH];
    logic [DISPLAY_LENGTH-1:0] cell_we;

    state_e                state_q;
    logic [AW-1:0]         cursor_q;
    logic                  full_q;
    logic [AW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] pending_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  wr_accept;

    assign o_wr_ready = (state_q == ST_IDLE);
    assign wr_accept  = i_wr_valid && o_wr_ready;
    assign o_cursor   = cursor_q;
    assign o_full     = full_q;
    assign o_rd_data  = rd_data_q;

    // Write FSM: cursor, full flag, sweep index and the character held across a scroll.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_CLEAR;
            cursor_q  <= '0;
            full_q    <= 1'b0;
            idx_q     <= '0;
            pending_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_accept) begin
                        case (i_wr_cmd)
                            CMD_CHAR: begin
                                if (!full_q) begin
                                    if (cursor_q == LastIdx) begin
                                        full_q <= 1'b1;
                                    end else begin
                                        cursor_q <= cursor_q + 1'b1;
                                    end
                                end else begin
                                    pending_q <= i_wr_data;
                                    idx_q     <= '0;
                                    state_q   <= ST_SCROLL;
                                end
                            end
                            CMD_BACKSPACE: begin
                                if (full_q) begin
                                    full_q <= 1'b0;
                                end else if (cursor_q != '0) begin
                                    cursor_q <= cursor_q - 1'b1;
                                end
                            end
                            CMD_CLEAR: begin
                                idx_q   <= '0;
                                state_q <= ST_CLEAR;
                            end
                            CMD_HOME: begin
                                cursor_q <= '0;
                                full_q   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SCROLL: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == PenultIdx) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        cursor_q <= '0;
                        full_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Per-cell write enables; the final scroll step writes two cells at once.
    always_comb begin
        cell_we = '0;
        for (int i = 0; i < DISPLAY_LENGTH; i++) begin
            cell_wd[i] = mem_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (wr_accept) begin
                    if (i_wr_cmd == CMD_CHAR && !full_q) begin
                        cell_we[cursor_q] = 1'b1;
                        cell_wd[cursor_q] = i_wr_data;
                    end else if (i_wr_cmd == CMD_BACKSPACE) begin
                        if (full_q) begin
                            cell_we[LastIdx] = 1'b1;
                            cell_wd[LastIdx] = BLANK_CHR;
                        end else if (cursor_q != '0) begin
                            cell_we[cursor_q - 1'b1] = 1'b1;
                            cell_wd[cursor_q - 1'b1] = BLANK_CHR;
                        end
                    end
                end
            end
            ST_SCROLL: begin
                cell_we[idx_q] = 1'b1;
                cell_wd[idx_q] = mem_q[idx_q + 1'b1];
                if (idx_q == PenultIdx) begin
                    cell_we[LastIdx] = 1'b1;
                    cell_wd[LastIdx] = pending_q;
                end
            end
            ST_CLEAR: begin
                cell_we[idx_q] = 1'b1;
                cell_wd[idx_q] = BLANK_CHR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DISPLAY_LENGTH; i++) begin
            if (cell_we[i]) begin
                mem_q[i] <= cell_wd[i];
            end
        end
    end

    always_comb begin
        rd_data_d = BLANK_CHR;
        if (i_rd_addr == cursor_q && !i_caret_strobe) begin
            rd_data_d = CARET_CHR;
        end else if (32'(i_rd_addr) < DISPLAY_LENGTH) begin
            rd_data_d = mem_q[i_rd_addr];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data_q <= BLANK_CHR;
        end else if (i_rd_en) begin
            rd_data_q <= rd_data_d;
        end
    end

endmodule
